// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute boundary: control-field layout,
// the bubble encoding and the operand-forwarding source numbering.
package pipe_pkg;

   // Destination register index width (32 architectural registers)
   localparam int REG_W = 5;

   // Field layout inside the packed control word
   localparam int CTRL_RF_WSEL_LSB = 0;
   localparam int CTRL_RF_WSEL_W   = 2;
   localparam int CTRL_RF_WE_LSB   = 2;
   localparam int CTRL_ALUB_LSB    = 3;
   localparam int CTRL_ALU_OP_LSB  = 4;
   localparam int CTRL_ALU_OP_W    = 4;
   localparam int CTRL_RAM_WE_LSB  = 8;
   localparam int CTRL_NPC_OP_LSB  = 9;
   localparam int CTRL_NPC_OP_W    = 3;

   // An all-zero control word writes neither the register file nor RAM
   localparam logic [15:0] CTRL_BUBBLE = '0;

   // Forwarding source numbering as seen on fwd_sel
   typedef enum logic [2:0] {
      FWD_RF   = 3'd0,
      FWD_EX   = 3'd1,
      FWD_MEM  = 3'd2,
      FWD_WB   = 3'd3,
      FWD_LOAD = 3'd4
   } fwd_src_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: 0 keeps the register-file value, 1..NFWD pick a
// bypass source; any larger select value falls back to the register file.
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NFWD   = 4,
   parameter int SEL_W  = 3
) (
   input  logic [DATA_W-1:0]      rf_data,
   input  logic [NFWD*DATA_W-1:0] fwd_data,
   input  logic [SEL_W-1:0]       sel,
   output logic [DATA_W-1:0]      y
);

   // Default to the register-file read, override on a matching bypass source
   always_comb begin
      y = rf_data;
      for (int j = int'(FWD_EX); j <= NFWD; j++) begin
         if (sel == SEL_W'(j)) begin
            y = fwd_data[(j-1)*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-deep skid
// entry behind the main entry. Operands are bypass-resolved as they are
// captured, so the execute stage only ever sees final operand values.
module id_ex_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int NOPS   = 2,
   parameter int NFWD   = 4,
   parameter int SEL_W  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_pc,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_imm,
   input  logic [REG_W-1:0]       in_wr,
   input  logic [NOPS*DATA_W-1:0] in_op,
   input  logic [NFWD*DATA_W-1:0] fwd_data,
   input  logic [NOPS*SEL_W-1:0]  fwd_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_pc,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_imm,
   output logic [REG_W-1:0]       out_wr,
   output logic [NOPS*DATA_W-1:0] out_op
);

   // Packed payload layout, LSB first: ops, wr, imm, ctrl, pc
   localparam int OPS_W    = NOPS * DATA_W;
   localparam int WR_LSB   = OPS_W;
   localparam int IMM_LSB  = WR_LSB + REG_W;
   localparam int CTRL_LSB = IMM_LSB + DATA_W;
   localparam int PC_LSB   = CTRL_LSB + CTRL_W;
   localparam int PAY_W    = PC_LSB + DATA_W;

   logic [OPS_W-1:0] fwd_ops_p0;
   logic [PAY_W-1:0] in_pay_p0;
   logic [PAY_W-1:0] main_p1;
   logic [PAY_W-1:0] skid_p1;
   logic             main_vld_p1;
   logic             skid_vld_p1;
   logic             accept;
   logic             fire;

   // ---- stage p0: bypass resolution and payload packing ----
   for (genvar k = 0; k < NOPS; k++) begin : g_fwd
      fwd_mux #(
         .DATA_W (DATA_W),
         .NFWD   (NFWD),
         .SEL_W  (SEL_W)
      ) u_fwd_mux (
         .rf_data  (in_op[k*DATA_W +: DATA_W]),
         .fwd_data (fwd_data),
         .sel      (fwd_sel[k*SEL_W +: SEL_W]),
         .y        (fwd_ops_p0[k*DATA_W +: DATA_W])
      );
   end

   assign in_pay_p0 = {in_pc, in_ctrl, in_imm, in_wr, fwd_ops_p0};

   // in_ready comes from a register only, so out_ready never reaches it
   assign in_ready = !skid_vld_p1;
   assign accept   = in_valid && in_ready;
   assign fire     = main_vld_p1 && out_ready;

   // ---- stage p1: main and skid entries ----
   // Main refills from skid first, then from the input, else becomes a zeroed bubble;
   // skid only captures when main is stalled. Flush discards everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (flush) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (!main_vld_p1 || fire) begin
         if (skid_vld_p1) begin
            main_p1     <= skid_p1;
            main_vld_p1 <= 1'b1;
            skid_vld_p1 <= 1'b0;
         end else if (accept) begin
            main_p1     <= in_pay_p0;
            main_vld_p1 <= 1'b1;
         end else begin
            main_p1     <= '0;
            main_vld_p1 <= 1'b0;
         end
      end else if (accept) begin
         skid_p1     <= in_pay_p0;
         skid_vld_p1 <= 1'b1;
      end
   end

   assign out_valid = main_vld_p1;
   assign out_pc    = main_p1[PC_LSB   +: DATA_W];
   assign out_ctrl  = main_p1[CTRL_LSB +: CTRL_W];
   assign out_imm   = main_p1[IMM_LSB  +: DATA_W];
   assign out_wr    = main_p1[WR_LSB   +: REG_W];
   assign out_op    = main_p1[0        +: OPS_W];

endmodule
